// File: rtl/clock_seq_pkg.sv
// Clock sequencer shared definitions.
// State encoding and segment field offsets.
package clock_seq_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARMED = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;

    function automatic int seg_width(input int cnt_w, input int rep_w);
        return 2 * cnt_w + rep_w + 1;
    endfunction

    function automatic int off_lsb(input int rep_w);
        return rep_w;
    endfunction

    function automatic int on_lsb(input int cnt_w, input int rep_w);
        return cnt_w + rep_w;
    endfunction

    function automatic int last_bit(input int cnt_w, input int rep_w);
        return 2 * cnt_w + rep_w;
    endfunction

endpackage

// File: rtl/clock_seq_if.sv
// Segment descriptor handshake between a segment source
// and the clock sequencer.
interface clock_seq_if
    import clock_seq_pkg::*;
#(
    parameter int SEG_W = seg_width(48, 32)
);
    logic [SEG_W-1:0] seg_data;
    logic             seg_valid;
    logic             seg_ready;

    modport master (
        output seg_data,
        output seg_valid,
        input  seg_ready
    );

    modport slave (
        input  seg_data,
        input  seg_valid,
        output seg_ready
    );
endinterface

// File: rtl/clock_seq_period_ctr.sv
// Period/repeat counter for one segment.
// high_o is the level for the cycle after this edge.
module clock_seq_period_ctr #(
    parameter int CNT_W = 48,
    parameter int REP_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             adv_i,
    input  logic [CNT_W-1:0] on_i,
    input  logic [CNT_W-1:0] off_i,
    input  logic [REP_W-1:0] rep_i,
    output logic             high_o,
    output logic             period_end_o,
    output logic             segment_end_o
);
    localparam int PW = CNT_W + 1;

    logic [PW-1:0]    per_q, per_d;
    logic [PW-1:0]    ph_q, ph_d;
    logic [CNT_W-1:0] on_q, on_d;
    logic [REP_W-1:0] rep_q, rep_d;

    assign period_end_o  = (ph_q == per_q - PW'(1));
    assign segment_end_o = period_end_o && (rep_q == '0);
    assign high_o        = (ph_d < {1'b0, on_d});

    // rep_q holds the repeats still to run after the current one
    always_comb begin
        per_d = per_q;
        ph_d  = ph_q;
        on_d  = on_q;
        rep_d = rep_q;
        if (load_i) begin
            on_d  = on_i;
            per_d = {1'b0, on_i} + {1'b0, off_i};
            ph_d  = '0;
            rep_d = (rep_i == '0) ? '0 : rep_i - REP_W'(1);
        end else if (adv_i) begin
            if (period_end_o) begin
                ph_d  = '0;
                rep_d = rep_q - REP_W'(1);
            end else begin
                ph_d  = ph_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_q <= '0;
            ph_q  <= '0;
            on_q  <= '0;
            rep_q <= '0;
        end else begin
            per_q <= per_d;
            ph_q  <= ph_d;
            on_q  <= on_d;
            rep_q <= rep_d;
        end
    end

endmodule

// File: rtl/clock_sequencer.sv
// Segment-driven clock generator with hard/soft triggers,
// retrigger waits and mistrigger detection.
module clock_sequencer
    import clock_seq_pkg::*;
#(
    parameter int CNT_W  = 48,
    parameter int REP_W  = 32,
    parameter int SAMP_W = 32,
    parameter int NOUT   = 4
) (
    input  logic              refclk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              use_hard_trig,
    input  logic              hard_trig,
    input  logic              retrig_in,
    clock_seq_if.slave        seg,
    output logic [NOUT-1:0]   clk_out,
    output logic              clk_out_n,
    output logic              toggle_out,
    input  logic              toggle_in,
    output logic [SAMP_W-1:0] mistrig_at,
    output logic [SAMP_W-1:0] samples,
    output logic [SAMP_W-1:0] master_samples,
    output logic              underrun,
    output logic [2:0]        state_o,
    output logic [7:0]        seg_count
);
    localparam int OFF_LSB = off_lsb(REP_W);
    localparam int ON_LSB  = on_lsb(CNT_W, REP_W);
    localparam int LAST_B  = last_bit(CNT_W, REP_W);

    logic [2:0]        state_q, state_d;
    logic              hard_q, last_q, last_d, got_q, got_d;
    logic [NOUT-1:0]   clk_q;
    logic              clkn_q, tog_q, rdy_q;
    logic [SAMP_W-1:0] samp_q, samp_d, mis_q, mis_d;
    logic [SAMP_W-1:0] mast_q, mast_d;
    logic              und_q, und_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              load, adv, hi, pend, send;
    logic              clk_d, rise, hard_rise, hs;

    logic [CNT_W-1:0] seg_on, seg_off;
    logic [REP_W-1:0] seg_rep;
    logic             seg_last;

    assign seg_on    = seg.seg_data[ON_LSB +: CNT_W];
    assign seg_off   = seg.seg_data[OFF_LSB +: CNT_W];
    assign seg_rep   = seg.seg_data[0 +: REP_W];
    assign seg_last  = seg.seg_data[LAST_B];
    assign hs        = seg.seg_valid && rdy_q;
    assign hard_rise = hard_trig && !hard_q;
    assign adv       = (state_q == ST_RUN);

    clock_seq_period_ctr #(
        .CNT_W (CNT_W),
        .REP_W (REP_W)
    ) u_ctr (
        .clk           (refclk),
        .rst_n         (reset_n),
        .load_i        (load),
        .adv_i         (adv),
        .on_i          (seg_on),
        .off_i         (seg_off),
        .rep_i         (seg_rep),
        .high_o        (hi),
        .period_end_o  (pend),
        .segment_end_o (send)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        got_d   = got_q;
        und_d   = und_q;
        cnt_d   = cnt_q;
        samp_d  = samp_q;
        mis_d   = mis_q;
        load    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = use_hard_trig ? ST_ARMED : ST_LOAD;
                    samp_d  = '0;
                    mis_d   = '0;
                    cnt_d   = '0;
                    und_d   = 1'b0;
                    got_d   = 1'b0;
                end
            end
            ST_ARMED: begin
                if (abort)          state_d = ST_IDLE;
                else if (hard_rise) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (hs) begin
                    load    = 1'b1;
                    last_d  = seg_last;
                    got_d   = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                    if (seg_on == '0 && seg_off == '0)
                        state_d = ST_WAIT;
                    else
                        state_d = ST_RUN;
                end else if (got_q) begin
                    // the first segment may stall; later gaps are underruns
                    und_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort)
                    state_d = ST_IDLE;
                else if (pend && send)
                    state_d = last_q ? ST_IDLE : ST_LOAD;
            end
            ST_WAIT: begin
                if (abort)
                    state_d = ST_IDLE;
                else if (retrig_in)
                    state_d = last_q ? ST_IDLE : ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase

        clk_d = (state_d == ST_RUN) && hi;
        rise  = clk_d && !clk_q[0];
        if (rise) begin
            samp_d = samp_q + SAMP_W'(1);
            if (tog_q != toggle_in && mis_q == '0)
                mis_d = samp_q + SAMP_W'(1);
        end
        mast_d = mast_q + SAMP_W'(adv);
    end

    always_ff @(posedge refclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            hard_q  <= 1'b0;
            last_q  <= 1'b0;
            got_q   <= 1'b0;
            clk_q   <= '0;
            clkn_q  <= 1'b1;
            tog_q   <= 1'b0;
            rdy_q   <= 1'b0;
            samp_q  <= '0;
            mis_q   <= '0;
            mast_q  <= '0;
            und_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hard_q  <= hard_trig;
            last_q  <= last_d;
            got_q   <= got_d;
            clk_q   <= {NOUT{clk_d}};
            clkn_q  <= ~clk_d;
            tog_q   <= tog_q ^ rise;
            rdy_q   <= (state_d == ST_LOAD);
            samp_q  <= samp_d;
            mis_q   <= mis_d;
            mast_q  <= mast_d;
            und_q   <= und_d;
            cnt_q   <= cnt_d;
        end
    end

    assign seg.seg_ready   = rdy_q;
    assign clk_out         = clk_q;
    assign clk_out_n       = clkn_q;
    assign toggle_out      = tog_q;
    assign mistrig_at      = mis_q;
    assign samples         = samp_q;
    assign master_samples  = mast_q;
    assign underrun        = und_q;
    assign state_o         = state_q;
    assign seg_count       = cnt_q;

endmodule

// File: tb/tb_clock_sequencer.sv
// Directed bench for clock_sequencer: segment playback,
// triggers, underrun, mistrigger, abort and reset.
module tb_clock_sequencer;
    import clock_seq_pkg::*;

    localparam int CNT_W  = 48;
    localparam int REP_W  = 32;
    localparam int SAMP_W = 32;
    localparam int NOUT   = 4;
    localparam int SEG_W  = seg_width(CNT_W, REP_W);

    logic              refclk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              use_hard_trig = 1'b0;
    logic              hard_trig = 1'b0;
    logic              retrig_in = 1'b0;
    logic              toggle_in = 1'b0;
    logic [NOUT-1:0]   clk_out;
    logic              clk_out_n;
    logic              toggle_out;
    logic [SAMP_W-1:0] mistrig_at;
    logic [SAMP_W-1:0] samples;
    logic [SAMP_W-1:0] master_samples;
    logic              underrun;
    logic [2:0]        state_o;
    logic [7:0]        seg_count;

    int checks = 0;
    int errors = 0;

    clock_seq_if #(.SEG_W(SEG_W)) seg_if ();

    clock_sequencer #(
        .CNT_W  (CNT_W),
        .REP_W  (REP_W),
        .SAMP_W (SAMP_W),
        .NOUT   (NOUT)
    ) dut (
        .refclk         (refclk),
        .reset_n        (reset_n),
        .start          (start),
        .abort          (abort),
        .use_hard_trig  (use_hard_trig),
        .hard_trig      (hard_trig),
        .retrig_in      (retrig_in),
        .seg            (seg_if),
        .clk_out        (clk_out),
        .clk_out_n      (clk_out_n),
        .toggle_out     (toggle_out),
        .toggle_in      (toggle_in),
        .mistrig_at     (mistrig_at),
        .samples        (samples),
        .master_samples (master_samples),
        .underrun       (underrun),
        .state_o        (state_o),
        .seg_count      (seg_count)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [SEG_W-1:0] mkseg(input int unsigned on,
        input int unsigned off, input int unsigned rep, input bit last);
        return {last, CNT_W'(on), CNT_W'(off), REP_W'(rep)};
    endfunction

    task automatic step();
        @(negedge refclk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        use_hard_trig = 1'b0;
        hard_trig = 1'b0;
        retrig_in = 1'b0;
        toggle_in = 1'b0;
        seg_if.seg_valid = 1'b0;
        seg_if.seg_data = '0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [9:0] pat;
        bit flag;
        int hicnt;

        // reset values
        do_reset();
        check("rst_state", state_o, ST_IDLE);
        check("rst_clk", clk_out, 0);
        check("rst_clkn", clk_out_n, 1);
        check("rst_tog", toggle_out, 0);
        check("rst_rdy", seg_if.seg_ready, 0);
        check("rst_samp", samples, 0);
        check("rst_master", master_samples, 0);
        check("rst_cnt", seg_count, 0);

        // on=2 off=3 rep=2 last=1; start during RUN ignored
        seg_if.seg_data = mkseg(2, 3, 2, 1);
        seg_if.seg_valid = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("s1_load", state_o, ST_LOAD);
        check("s1_rdy", seg_if.seg_ready, 1);
        step();
        seg_if.seg_valid = 1'b0;
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            pat = {pat[8:0], clk_out[0]};
            if (i == 0) begin
                check("s1_allcopies", clk_out, 4'hf);
                check("s1_clkn", clk_out_n, 0);
            end
            start = (i == 3);
            step();
        end
        check("s1_pattern", pat, 10'b1100011000);
        check("s1_idle", state_o, ST_IDLE);
        check("s1_clk_end", clk_out, 0);
        check("s1_samples", samples, 2);
        check("s1_segcnt", seg_count, 1);
        check("s1_master", master_samples, 10);
        check("s1_tog", toggle_out, 0);

        // A, wait segment, retrigger at t=20, C
        seg_if.seg_data = mkseg(1, 1, 1, 0);
        seg_if.seg_valid = 1'b1;
        start = 1'b1;
        flag = 1'b1;
        for (int t = 1; t <= 25; t++) begin
            step();
            start = 1'b0;
            if (t == 2) seg_if.seg_data = mkseg(0, 0, 0, 0);
            if (t == 5) seg_if.seg_valid = 1'b0;
            if (t >= 4 && t <= 21 && clk_out[0]) flag = 1'b0;
            retrig_in = (t == 20);
            if (t == 6) check("s2_wait_cnt", seg_count, 2);
            if (t == 20) check("s2_wait", state_o, ST_WAIT);
            if (t == 21) begin
                check("s2_reload", state_o, ST_LOAD);
                seg_if.seg_data = mkseg(2, 1, 1, 1);
                seg_if.seg_valid = 1'b1;
            end
            if (t == 22) begin
                check("s2_run_hi", clk_out, 4'hf);
                seg_if.seg_valid = 1'b0;
            end
        end
        check("s2_low_in_wait", flag, 1);
        check("s2_idle", state_o, ST_IDLE);
        check("s2_segcnt", seg_count, 3);
        check("s2_samples", samples, 2);
        check("s2_master", master_samples, 15);

        // hard trigger
        do_reset();
        use_hard_trig = 1'b1;
        seg_if.seg_data = mkseg(1, 1, 1, 1);
        seg_if.seg_valid = 1'b1;
        start = 1'b1;
        flag = 1'b1;
        for (int t = 1; t <= 14; t++) begin
            step();
            start = 1'b0;
            if (t <= 10 && (state_o != ST_ARMED || seg_if.seg_ready))
                flag = 1'b0;
            hard_trig = (t == 10);
            if (t == 11) begin
                check("s3_load", state_o, ST_LOAD);
                check("s3_low", clk_out, 0);
            end
            if (t == 12) begin
                check("s3_first_hi", clk_out, 4'hf);
                seg_if.seg_valid = 1'b0;
            end
            if (t == 14) check("s3_idle", state_o, ST_IDLE);
        end
        check("s3_armed", flag, 1);
        use_hard_trig = 1'b0;

        // first-segment stall, off=0, then underrun
        do_reset();
        start = 1'b1;
        hicnt = 0;
        for (int t = 1; t <= 16; t++) begin
            step();
            start = 1'b0;
            if (t >= 9 && t <= 14) hicnt += int'(clk_out[0]);
            if (t == 8) begin
                check("s4_stall", state_o, ST_LOAD);
                check("s4_no_und", underrun, 0);
                seg_if.seg_data = mkseg(3, 0, 2, 0);
                seg_if.seg_valid = 1'b1;
            end
            if (t == 9) seg_if.seg_valid = 1'b0;
            if (t == 15) begin
                check("s4_gap_low", clk_out, 0);
                check("s4_samples", samples, 1);
            end
        end
        check("s4_hicnt", hicnt, 6);
        check("s4_underrun", underrun, 1);
        check("s4_idle", state_o, ST_IDLE);
        check("s4_clk", clk_out, 0);
        check("s4_segcnt", seg_count, 1);

        // mistrigger with toggle_in stuck low
        do_reset();
        seg_if.seg_data = mkseg(1, 1, 4, 1);
        seg_if.seg_valid = 1'b1;
        start = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            step();
            start = 1'b0;
            if (t == 2) seg_if.seg_valid = 1'b0;
            if (t == 3) check("s5_mis_none", mistrig_at, 0);
            if (t == 4) check("s5_mis_first", mistrig_at, 2);
        end
        check("s5_idle", state_o, ST_IDLE);
        check("s5_mis_sticky", mistrig_at, 2);
        check("s5_samples", samples, 4);
        check("s5_tog", toggle_out, 0);
        use_hard_trig = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("s5_armed", state_o, ST_ARMED);
        check("s5_mis_clr", mistrig_at, 0);
        check("s5_samp_clr", samples, 0);
        abort = 1'b1;
        hard_trig = 1'b1;
        step();
        abort = 1'b0;
        hard_trig = 1'b0;
        check("s5_abort_armed", state_o, ST_IDLE);
        check("s5_abort_rdy", seg_if.seg_ready, 0);
        use_hard_trig = 1'b0;

        // on=0 low segment, wait, abort beats retrig
        do_reset();
        seg_if.seg_data = mkseg(0, 2, 1, 0);
        seg_if.seg_valid = 1'b1;
        start = 1'b1;
        flag = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            step();
            start = 1'b0;
            abort = 1'b0;
            retrig_in = 1'b0;
            if (clk_out[0]) flag = 1'b0;
            if (t == 2) seg_if.seg_data = mkseg(0, 0, 0, 0);
            if (t == 5) seg_if.seg_valid = 1'b0;
            if (t == 6) begin
                check("s6_wait", state_o, ST_WAIT);
                abort = 1'b1;
                retrig_in = 1'b1;
            end
        end
        check("s6_low", flag, 1);
        check("s6_idle", state_o, ST_IDLE);
        check("s6_rdy", seg_if.seg_ready, 0);
        check("s6_samples", samples, 0);
        check("s6_segcnt", seg_count, 2);

        // reset asserted mid-RUN
        seg_if.seg_data = mkseg(2, 2, 3, 1);
        seg_if.seg_valid = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("s7_run_hi", clk_out, 4'hf);
        #2;
        reset_n = 1'b0;
        #1;
        check("s7_clk", clk_out, 0);
        check("s7_clkn", clk_out_n, 1);
        check("s7_state", state_o, ST_IDLE);
        check("s7_rdy", seg_if.seg_ready, 0);
        check("s7_tog", toggle_out, 0);
        check("s7_samp", samples, 0);
        check("s7_master", master_samples, 0);
        flag = 1'b1;
        for (int t = 0; t < 3; t++) begin
            step();
            if (seg_if.seg_ready) flag = 1'b0;
        end
        check("s7_no_rdy", flag, 1);
        check("s7_segcnt", seg_count, 0);
        seg_if.seg_valid = 1'b0;
        reset_n = 1'b1;
        step();
        check("s7_after", state_o, ST_IDLE);
        check("s7_after_clk", clk_out, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
